// File: rtl/vex_bus_bridge.sv
// ---------------------------------------------------------------------------
// vex_bus_bridge
//
// Responder end of the VexRiscv simple iBus/dBus interface. Instruction
// fetches and data commands are arbitrated onto one shared memory bus with
// 1-cycle read latency (RAM, MMIO, ROM). Each read gets exactly one
// response in the following cycle. Writes get no response and can be
// issued back to back. The bridge issues nothing while the debug unit
// owns the shared bus (bus_busy).
//
// Parameters:
//   MAP_TOP   first unmapped address. Commands at or above it get an error
//             response and no bus cycle.
//
// Optional feature macro:
//   VEXBUS_FAIR_ARB_EN  when defined, a simultaneous iBus/dBus request
//                       goes to iBus if the previous grant went to dBus.
//                       Otherwise dBus always has priority.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ibus_cmd_valid/ready/pc    fetch command handshake and address
//   ibus_rsp_valid/error/inst  fetch response pulse, error flag, word
//   dbus_cmd_valid/ready       data command handshake
//   dbus_cmd_wr/mask/address/data/size  data command payload (size unused)
//   dbus_rsp_ready/error/data  read response pulse, error flag, word
//   bus_busy                   debugger owns the shared bus this cycle
//   mem_op/adr/wren/di         shared-bus strobe, address, byte writes, data
//   mem_do                     shared-bus read data, one cycle after mem_op
// ---------------------------------------------------------------------------
module vex_bus_bridge #(
  parameter logic [31:0] MAP_TOP = 32'h0003_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ibus_cmd_valid,
  output logic        ibus_cmd_ready,
  input  logic [31:0] ibus_cmd_pc,
  output logic        ibus_rsp_valid,
  output logic        ibus_rsp_error,
  output logic [31:0] ibus_rsp_inst,
  input  logic        dbus_cmd_valid,
  output logic        dbus_cmd_ready,
  input  logic        dbus_cmd_wr,
  input  logic [3:0]  dbus_cmd_mask,
  input  logic [31:0] dbus_cmd_address,
  input  logic [31:0] dbus_cmd_data,
  input  logic [1:0]  dbus_cmd_size,
  output logic        dbus_rsp_ready,
  output logic        dbus_rsp_error,
  output logic [31:0] dbus_rsp_data,
  input  logic        bus_busy,
  output logic        mem_op,
  output logic [31:0] mem_adr,
  output logic [3:0]  mem_wren,
  output logic [31:0] mem_di,
  input  logic [31:0] mem_do
);

  typedef enum logic [1:0] {IDLE, IRESP, DRESP} state_t;

  state_t      state, next_state;
  logic        err_q, err_d;
  logic        grant_d, grant_i;
  logic        mapped;
  logic [31:0] grant_addr;

  // Access size only matters to the CPU; the byte mask already says it all.
  logic unused_size;
  assign unused_size = ^dbus_cmd_size;

`ifdef VEXBUS_FAIR_ARB_EN
  logic last_d;
`endif

  // Arbitration: only in IDLE, out of reset, and while the debugger is off
  // the bus. Pending commands simply wait with valid held high.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (!reset && state == IDLE && !bus_busy) begin
`ifdef VEXBUS_FAIR_ARB_EN
      grant_d = dbus_cmd_valid && !(ibus_cmd_valid && last_d);
`else
      grant_d = dbus_cmd_valid;
`endif
      grant_i = ibus_cmd_valid && !grant_d;
    end
  end

  assign grant_addr = grant_d ? dbus_cmd_address : ibus_cmd_pc;
  assign mapped     = grant_addr < MAP_TOP;

  // Next state and all outputs. Unmapped grants still handshake but never
  // touch the bus; their error is remembered for the response cycle. The
  // response data is taken straight from mem_do because the bus answers
  // exactly one cycle after the strobe.
  always_comb begin
    next_state     = state;
    err_d          = err_q;
    ibus_cmd_ready = 1'b0;
    dbus_cmd_ready = 1'b0;
    ibus_rsp_valid = 1'b0;
    ibus_rsp_error = 1'b0;
    ibus_rsp_inst  = 32'h0;
    dbus_rsp_ready = 1'b0;
    dbus_rsp_error = 1'b0;
    dbus_rsp_data  = 32'h0;
    mem_op         = 1'b0;
    mem_adr        = 32'h0;
    mem_wren       = 4'h0;
    mem_di         = 32'h0;
    if (reset) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d || grant_i) begin
            dbus_cmd_ready = grant_d;
            ibus_cmd_ready = grant_i;
            if (mapped) begin
              mem_op   = 1'b1;
              mem_adr  = grant_addr;
              mem_di   = dbus_cmd_data;
              mem_wren = (grant_d && dbus_cmd_wr) ? dbus_cmd_mask : 4'h0;
            end
            if (grant_i) begin
              next_state = IRESP;
              err_d      = !mapped;
            end else if (!dbus_cmd_wr) begin
              next_state = DRESP;
              err_d      = !mapped;
            end
          end
        end
        IRESP: begin
          ibus_rsp_valid = 1'b1;
          ibus_rsp_error = err_q;
          ibus_rsp_inst  = err_q ? 32'h0 : mem_do;
          next_state     = IDLE;
        end
        DRESP: begin
          dbus_rsp_ready = 1'b1;
          dbus_rsp_error = err_q;
          dbus_rsp_data  = err_q ? 32'h0 : mem_do;
          next_state     = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= next_state;
      err_q <= err_d;
    end
  end

`ifdef VEXBUS_FAIR_ARB_EN
  // Remembers who won the most recent grant, reads and writes alike.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_d <= 1'b0;
    end else if (grant_d || grant_i) begin
      last_d <= grant_d;
    end
  end
`endif

endmodule

// File: tb/tb_vex_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_vex_bus_bridge
//
// Self-checking bench for vex_bus_bridge. A small memory slave answers the
// shared bus; a transaction-level model predicts every output each cycle.
// Directed scenarios with literal expectations come first, then a long
// randomized run with CPU-like held requests, debugger stalls and resets.
// ---------------------------------------------------------------------------
module tb_vex_bus_bridge;

  localparam logic [31:0] MAP_TOP = 32'h0003_0000;
`ifdef VEXBUS_FAIR_ARB_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ibus_cmd_valid, ibus_cmd_ready;
  logic [31:0] ibus_cmd_pc;
  logic        ibus_rsp_valid, ibus_rsp_error;
  logic [31:0] ibus_rsp_inst;
  logic        dbus_cmd_valid, dbus_cmd_ready, dbus_cmd_wr;
  logic [3:0]  dbus_cmd_mask;
  logic [31:0] dbus_cmd_address, dbus_cmd_data;
  logic [1:0]  dbus_cmd_size;
  logic        dbus_rsp_ready, dbus_rsp_error;
  logic [31:0] dbus_rsp_data;
  logic        bus_busy;
  logic        mem_op;
  logic [31:0] mem_adr, mem_di;
  logic [3:0]  mem_wren;
  logic [31:0] mem_do = 32'h0;

  int checks = 0;
  int errors = 0;

  vex_bus_bridge #(.MAP_TOP(MAP_TOP)) dut (
    .clk(clk), .reset(reset),
    .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_ready(ibus_cmd_ready),
    .ibus_cmd_pc(ibus_cmd_pc),
    .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_error(ibus_rsp_error),
    .ibus_rsp_inst(ibus_rsp_inst),
    .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready),
    .dbus_cmd_wr(dbus_cmd_wr), .dbus_cmd_mask(dbus_cmd_mask),
    .dbus_cmd_address(dbus_cmd_address), .dbus_cmd_data(dbus_cmd_data),
    .dbus_cmd_size(dbus_cmd_size),
    .dbus_rsp_ready(dbus_rsp_ready), .dbus_rsp_error(dbus_rsp_error),
    .dbus_rsp_data(dbus_rsp_data),
    .bus_busy(bus_busy),
    .mem_op(mem_op), .mem_adr(mem_adr), .mem_wren(mem_wren),
    .mem_di(mem_di), .mem_do(mem_do)
  );

  always #5 clk = ~clk;

  // Sparse word memory; untouched words read as an address hash.
  logic [31:0] mem_arr [bit [29:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_arr.exists(a[31:2])) return mem_arr[a[31:2]];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic busy,
                               input logic iv, input logic [31:0] pc,
                               input logic dv, input logic wr,
                               input logic [3:0] mask, input logic [31:0] addr,
                               input logic [31:0] data);
    reset            = rst;
    bus_busy         = busy;
    ibus_cmd_valid   = iv;
    ibus_cmd_pc      = pc;
    dbus_cmd_valid   = dv;
    dbus_cmd_wr      = wr;
    dbus_cmd_mask    = mask;
    dbus_cmd_address = addr;
    dbus_cmd_data    = data;
    dbus_cmd_size    = 2'd2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory slave: watches the bus mid-cycle, commits writes at the edge and
  // presents read data one cycle after a read strobe.
  initial begin
    logic        cap_op;
    logic [31:0] cap_adr, cap_di;
    logic [3:0]  cap_wren;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      cap_op = mem_op; cap_adr = mem_adr; cap_di = mem_di; cap_wren = mem_wren;
      @(posedge clk);
      if (cap_op && cap_wren != 4'h0) begin
        w = mem_rd(cap_adr);
        for (int b = 0; b < 4; b++)
          if (cap_wren[b]) w[b*8 +: 8] = cap_di[b*8 +: 8];
        mem_arr[cap_adr[31:2]] = w;
      end
      #1;
      mem_do = (cap_op && cap_wren == 4'h0) ? mem_rd(cap_adr) : $urandom;
    end
  end

  // Transaction-level reference: at most one outstanding read, answered the
  // cycle after its grant unless reset intervenes.
  int          pend_kind = 0;  // 0 none, 1 fetch, 2 data read
  logic [31:0] pend_addr = 32'h0;
  bit          last_was_d = 1'b0;
  bit          m_acc_i = 1'b0, m_acc_d = 1'b0;

  initial begin
    bit          gi, gd, map;
    logic [31:0] a;
    logic [31:0] e_adr, e_di, e_inst, e_ddata;
    logic [3:0]  e_wren;
    logic        e_op, e_iv, e_ie, e_dv, e_de;
    forever begin
      @(negedge clk);
      gi = 0; gd = 0; map = 0; a = 0;
      e_op = 0; e_adr = 0; e_di = 0; e_wren = 0;
      e_iv = 0; e_ie = 0; e_inst = 0; e_dv = 0; e_de = 0; e_ddata = 0;
      if (!reset) begin
        if (pend_kind != 0) begin
          map = pend_addr < MAP_TOP;
          if (pend_kind == 1) begin
            e_iv = 1; e_ie = !map; e_inst = map ? mem_rd(pend_addr) : 0;
          end else begin
            e_dv = 1; e_de = !map; e_ddata = map ? mem_rd(pend_addr) : 0;
          end
        end else if (!bus_busy) begin
          gd = dbus_cmd_valid && !(FAIR && ibus_cmd_valid && last_was_d);
          gi = ibus_cmd_valid && !gd;
          a = gd ? dbus_cmd_address : ibus_cmd_pc;
          if ((gd || gi) && a < MAP_TOP) begin
            e_op = 1; e_adr = a; e_di = dbus_cmd_data;
            e_wren = (gd && dbus_cmd_wr) ? dbus_cmd_mask : 4'h0;
          end
        end
      end
      checkOutput("cmd_ready", {30'h0, ibus_cmd_ready, dbus_cmd_ready}, {30'h0, gi, gd});
      checkOutput("mem_op", {31'h0, mem_op}, {31'h0, e_op});
      checkOutput("mem_adr", mem_adr, e_adr);
      checkOutput("mem_wren", {28'h0, mem_wren}, {28'h0, e_wren});
      checkOutput("mem_di", mem_di, e_di);
      checkOutput("ibus_rsp", {30'h0, ibus_rsp_valid, ibus_rsp_error}, {30'h0, e_iv, e_ie});
      checkOutput("ibus_inst", ibus_rsp_inst, e_inst);
      checkOutput("dbus_rsp", {30'h0, dbus_rsp_ready, dbus_rsp_error}, {30'h0, e_dv, e_de});
      checkOutput("dbus_data", dbus_rsp_data, e_ddata);
      m_acc_i = gi; m_acc_d = gd;
      if (reset) begin
        pend_kind = 0; last_was_d = 0;
      end else if (pend_kind != 0) begin
        pend_kind = 0;
      end else if (gd || gi) begin
        last_was_d = gd;
        pend_addr  = a;
        if (gi) pend_kind = 1;
        else if (!dbus_cmd_wr) pend_kind = 2;
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return 32'h0003_0000;
      1: return 32'h0002_FFFC;
      2: return 32'hFFFF_FFFC;
      3: return $urandom;
      4, 5: return 32'h0001_0000 + {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      default: return {14'h0, 16'($urandom_range(0, 16'hBFFF)), 2'b00};
    endcase
  endfunction

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_arr[30'h0000_8000] = 32'h0000_0013;

    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_flags",
                  {26'h0, ibus_cmd_ready, dbus_cmd_ready, ibus_rsp_valid,
                   dbus_rsp_ready, mem_op, |mem_wren}, 32'h0);
      checkOutput("reset_adr", mem_adr, 32'h0);
    end

    // Back-to-back writes, no response.
    step(); applyStimulus(0, 0, 0, 0, 1, 1, 4'b0001, 32'h0001_0010, 32'h41);
    @(negedge clk);
    checkOutput("wr0_wren", {28'h0, mem_wren}, 32'h1);
    checkOutput("wr0_di", mem_di, 32'h41);
    step(); applyStimulus(0, 0, 0, 0, 1, 1, 4'b1111, 32'h0001_0014, 32'h55);
    @(negedge clk);
    checkOutput("wr1_issue", {31'h0, dbus_cmd_ready}, 32'h1);
    checkOutput("wr1_adr", mem_adr, 32'h0001_0014);
    step(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("wr_no_rsp", {31'h0, dbus_rsp_ready}, 32'h0);

    // Fetch with 1-cycle response.
    step(); applyStimulus(0, 0, 1, 32'h0002_0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("fetch_ready", {31'h0, ibus_cmd_ready}, 32'h1);
    checkOutput("fetch_adr", mem_adr, 32'h0002_0000);
    checkOutput("fetch_op", {27'h0, mem_op, mem_wren}, 32'h10);
    step(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("fetch_rsp", {30'h0, ibus_rsp_valid, ibus_rsp_error}, 32'h2);
    checkOutput("fetch_inst", ibus_rsp_inst, 32'h13);

    // Simultaneous requests: dBus first, then iBus.
    step(); applyStimulus(0, 0, 1, 32'h0000_0400, 1, 0, 0, 32'h0000_0100, 0);
    @(negedge clk);
    checkOutput("dual_c0", {30'h0, ibus_cmd_ready, dbus_cmd_ready}, 32'h1);
    step(); applyStimulus(0, 0, 1, 32'h0000_0400, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("dual_c1", {30'h0, ibus_cmd_ready, dbus_rsp_ready}, 32'h1);
    step();
    @(negedge clk);
    checkOutput("dual_c2", {30'h0, ibus_cmd_ready, dbus_cmd_ready}, 32'h2);
    step(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("dual_c3", {31'h0, ibus_rsp_valid}, 32'h1);

    // Held dual request: second grant alternates only with fair arbitration.
    step(); applyStimulus(0, 0, 1, 32'h0000_0600, 1, 0, 0, 32'h0000_0104, 0);
    @(negedge clk);
    checkOutput("rep_c0", {30'h0, ibus_cmd_ready, dbus_cmd_ready}, 32'h1);
    step(); @(negedge clk);
    step(); @(negedge clk);
    checkOutput("rep_c2", {30'h0, ibus_cmd_ready, dbus_cmd_ready}, FAIR ? 32'h2 : 32'h1);
    step(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Unmapped fetch.
    step(); applyStimulus(0, 0, 1, 32'h0003_0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("unmap_c0", {30'h0, ibus_cmd_ready, mem_op}, 32'h2);
    step(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("unmap_rsp", {30'h0, ibus_rsp_valid, ibus_rsp_error}, 32'h3);
    checkOutput("unmap_inst", ibus_rsp_inst, 32'h0);

    // Debugger holds the bus for three cycles.
    for (int c = 0; c < 3; c++) begin
      step(); applyStimulus(0, 1, 0, 0, 1, 0, 0, 32'h0000_0200, 0);
      @(negedge clk);
      checkOutput("busy_hold", {30'h0, dbus_cmd_ready, mem_op}, 32'h0);
    end
    step(); applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h0000_0200, 0);
    @(negedge clk);
    checkOutput("busy_grant", {31'h0, dbus_cmd_ready}, 32'h1);
    step(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("busy_rsp", {31'h0, dbus_rsp_ready}, 32'h1);

    // Reset while a read response is pending.
    step(); applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h0000_0300, 0);
    @(negedge clk);
    checkOutput("rst_grant", {31'h0, dbus_cmd_ready}, 32'h1);
    step(); applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst_c1", {31'h0, dbus_rsp_ready}, 32'h0);
    step(); applyStimulus(0, 0, 1, 32'h0000_0500, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst_c2", {30'h0, ibus_cmd_ready, dbus_rsp_ready}, 32'h2);
    step(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Randomized traffic: requests stay up until the model says they were
    // accepted, like the CPU does.
    for (int n = 0; n < 4000; n++) begin
      step();
      reset    = ($urandom_range(0, 99) == 0);
      bus_busy = ($urandom_range(0, 4) == 0);
      if (m_acc_d || !dbus_cmd_valid) begin
        dbus_cmd_valid   = $urandom_range(0, 1);
        dbus_cmd_wr      = $urandom_range(0, 1);
        dbus_cmd_mask    = 4'($urandom);
        dbus_cmd_address = rand_addr();
        dbus_cmd_data    = $urandom;
        dbus_cmd_size    = 2'($urandom);
      end
      if (m_acc_i || !ibus_cmd_valid) begin
        ibus_cmd_valid = $urandom_range(0, 1);
        ibus_cmd_pc    = rand_addr();
      end
    end
    step(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vex_bus_bridge.md
Name: vex_bus_bridge

Overview:
- Responder end of the VexRiscv simple iBus/dBus interface.
- Accepts instruction-fetch and data commands from the CPU, arbitrates them onto the single shared memory bus, and returns one response per read.
- The shared memory bus has 1-cycle read latency and drives RAM, MMIO and ROM.
- Yields the shared bus to the debug unit when `bus_busy` is high.
- Replaces the ad-hoc ready/valid glue in the SoC top.

Parameters:
- MAP_TOP, 32'h0003_0000: first unmapped address. Commands with address >= MAP_TOP get an error response and no bus cycle.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ibus_cmd_valid  in  1  fetch request
- ibus_cmd_ready  out  1  fetch accepted this cycle
- ibus_cmd_pc  in  32  fetch address
- ibus_rsp_valid  out  1  fetch response pulse
- ibus_rsp_error  out  1  fetch error
- ibus_rsp_inst  out  32  fetched word
- dbus_cmd_valid  in  1  data request
- dbus_cmd_ready  out  1  data command accepted
- dbus_cmd_wr  in  1  write when 1
- dbus_cmd_mask  in  4  byte enables
- dbus_cmd_address  in  32  data address
- dbus_cmd_data  in  32  write data
- dbus_cmd_size  in  2  log2 access bytes; informational only
- dbus_rsp_ready  out  1  read response pulse
- dbus_rsp_error  out  1  read error
- dbus_rsp_data  out  32  read word
- bus_busy  in  1  debugger owns the shared bus this cycle
- mem_op  out  1  shared-bus access strobe
- mem_adr  out  32  shared-bus address
- mem_wren  out  4  byte write enables; 0 = read
- mem_di  out  32  write data to memory
- mem_do  in  32  read data, valid the cycle after the mem_op read

Behaviour:
- States: IDLE, IRESP, DRESP. Reset value is IDLE.
- Outputs during and after reset: all ready/rsp/mem_op/mem_wren are 0; mem_adr=0, mem_di=0 whenever mem_op=0.
- Issue rule: combinational, only in IDLE, only when reset=0 and bus_busy=0.
  - Grant dBus if dbus_cmd_valid, else iBus if ibus_cmd_valid.
  - Exactly one cmd_ready is high for 1 cycle in the grant cycle.
- Mapped grant (address < MAP_TOP):
  - mem_op=1; mem_adr = the granted address; mem_di = dbus_cmd_data.
  - mem_wren = dbus_cmd_mask for dBus writes; 0 for dBus reads and all fetches.
- Unmapped grant: mem_op=0; cmd_ready still pulses.
- dBus write grant: state stays IDLE. No response. Next grant is possible the following cycle, so writes sustain 1 per cycle. Unmapped writes are dropped silently.
- dBus read grant: next state DRESP.
  - In DRESP: dbus_rsp_ready=1 for exactly 1 cycle.
  - dbus_rsp_data = mem_do (combinational), or 0 if the access was unmapped.
  - dbus_rsp_error = the registered unmapped flag.
  - Returns to IDLE; no issue occurs in DRESP.
- iBus grant: next state IRESP, symmetric to DRESP, using ibus_rsp_valid/inst/error.
- Read throughput: 1 read per 2 cycles.
- Address comparison is 32-bit unsigned, so 32'hFFFF_FFFC is unmapped.
- bus_busy high in IDLE: no grant, pending commands are held. The CPU keeps valid high; the grant happens in the first cycle bus_busy=0.
- bus_busy high in IRESP/DRESP: the response is still delivered. mem_do reflects the previous cycle's access, and the debugger's access only starts this cycle.
- Simultaneous ibus/dbus valid: dBus wins (default priority).
- Reset asserted in IRESP/DRESP: the pending response is discarded, no rsp pulse occurs, and the next state is IDLE.
- Response payload outputs are 0 when their valid/ready is 0.

Optional Feature:
- VEXBUS_FAIR_ARB_EN defined:
  - A 1-bit register `last_d` records whether the previous grant went to dBus.
  - When both requests are valid in IDLE and last_d=1, iBus is granted instead.
  - last_d is reset to 0.
- Undefined: fixed dBus priority as in Behaviour. No extra register.

Test Plan:
- Fetch at 0x00020000 with mem_do=0x00000013 on the following cycle -> ibus_cmd_ready in cycle 0 with mem_op=1, mem_wren=0, mem_adr=0x00020000; ibus_rsp_valid=1 in cycle 1 with inst=0x00000013, error=0.
- dBus write addr 0x00010010, mask 4'b0001, data 0x41, then a second write on the next cycle -> mem_wren=4'b0001 with mem_di=0x41 in cycle 0; second write issued in cycle 1; dbus_rsp_ready never asserts.
- ibus_cmd_valid and dbus read (0x00000100) both valid in cycle 0 -> dBus granted cycle 0, response cycle 1; iBus granted cycle 2, response cycle 3. With VEXBUS_FAIR_ARB_EN and a repeated dual request, the next grant alternates to iBus.
- Fetch at 0x00030000 -> cmd_ready cycle 0, mem_op=0; cycle 1 ibus_rsp_valid=1, ibus_rsp_error=1, inst=0.
- bus_busy=1 for cycles 0-2 with dBus read pending -> no ready/mem_op in cycles 0-2; grant in cycle 3; dbus_rsp_ready in cycle 4.
- dBus read granted cycle 0, reset=1 in cycle 1 -> no dbus_rsp_ready in cycle 1 or 2; state IDLE; a new fetch is granted in the first cycle after reset deasserts.
